// File: rtl/perip_bridge_pkg.sv
// Shared constants and types for the peripheral bridge: address map,
// register offsets, decode targets and UART transmitter states.
package perip_bridge_pkg;

    localparam logic [31:0] DRAM_BASE_DEF  = 32'h8010_0000;
    localparam logic [31:0] PERIP_BASE_DEF = 32'h8020_0000;

    localparam logic [5:0] OFF_TXDATA      = 6'h00;
    localparam logic [5:0] OFF_STATUS      = 6'h04;
    localparam logic [5:0] OFF_BAUD        = 6'h08;
    localparam logic [5:0] OFF_MTIME_LO    = 6'h10;
    localparam logic [5:0] OFF_MTIME_HI    = 6'h14;
    localparam logic [5:0] OFF_MTIMECMP_LO = 6'h18;
    localparam logic [5:0] OFF_MTIMECMP_HI = 6'h1C;

    typedef enum logic [1:0] {
        TGT_RAM,
        TGT_REG,
        TGT_NONE
    } tgt_e;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/perip_bridge_uart_tx_fsm.sv
// 8N1 UART transmitter; each symbol lasts baud cycles (0 treated as 1).
//
// state      | meaning
// UART_IDLE  | line high, waiting for start
// UART_START | start bit (0)
// UART_DATA  | 8 data bits, LSB first
// UART_STOP  | stop bit (1), then back to idle
module uart_tx_fsm
    import perip_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] baud,
    input  logic        start,
    input  logic [7:0]  data,
    output logic        tx,
    output logic        busy
);

    uart_state_e state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  data_q, data_n;
    logic        tx_n;
    logic [15:0] baud_eff;
    logic        tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= UART_IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            data_q  <= 8'd0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            data_q  <= data_n;
            tx      <= tx_n;
        end
    end

    // Down-counter reloads from the live divisor, so BAUD changes land at the next symbol.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        data_n    = data_q;
        tx_n      = 1'b1;
        baud_eff  = (baud == 16'd0) ? 16'd1 : baud;
        tc        = (cnt <= 16'd1);
        case (state)
            UART_IDLE: begin
                if (start) begin
                    state_n = UART_START;
                    cnt_n   = baud_eff;
                    data_n  = data;
                end
            end
            UART_START: begin
                if (tc) begin
                    state_n   = UART_DATA;
                    cnt_n     = baud_eff;
                    bit_idx_n = 3'd0;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            UART_DATA: begin
                if (tc) begin
                    cnt_n = baud_eff;
                    if (bit_idx == 3'd7) state_n = UART_STOP;
                    else bit_idx_n = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            UART_STOP: begin
                if (tc) state_n = UART_IDLE;
                else cnt_n = cnt - 16'd1;
            end
            default: state_n = UART_IDLE;
        endcase
        case (state_n)
            UART_START: tx_n = 1'b0;
            UART_DATA:  tx_n = data_n[bit_idx_n];
            default:    tx_n = 1'b1;
        endcase
    end

    assign busy = (state != UART_IDLE);

endmodule

// File: rtl/perip_bridge.sv
// Core peripheral-port bridge: decodes accesses to data RAM, UART and machine timer.
module perip_bridge
    import perip_bridge_pkg::*;
#(
    parameter int unsigned DRAM_WORDS   = 4096,
    parameter logic [31:0] DRAM_BASE    = DRAM_BASE_DEF,
    parameter logic [31:0] PERIP_BASE   = PERIP_BASE_DEF,
    parameter logic [15:0] BAUD_DIV_RST = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] perip_addr,
    input  logic        perip_wen,
    input  logic [3:0]  perip_mask,
    input  logic [31:0] perip_wdata,
    output logic [31:0] perip_rdata,
    output logic        uart_tx,
    output logic        timer_irq
);

    localparam int          AW        = $clog2(DRAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DRAM_WORDS);

    logic [31:0] mem [DRAM_WORDS];
    logic [31:0] ram_off;
    logic [AW-1:0] ram_idx;
    logic [5:0]  reg_off;
    tgt_e        tgt;
    logic        wr_reg;
    logic        unused_bits;

    logic [15:0] baud;
    logic        overflow;
    logic        busy;
    logic        tx_start;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    assign ram_off     = perip_addr - DRAM_BASE;
    assign ram_idx     = ram_off[AW+1:2];
    assign reg_off     = {perip_addr[5:2], 2'b00};
    assign unused_bits = ^{ram_off[31:AW+2], ram_off[1:0]};

    always_comb begin
        tgt = TGT_NONE;
        if (ram_off < RAM_BYTES) tgt = TGT_RAM;
        else if (perip_addr[31:6] == PERIP_BASE[31:6]) tgt = TGT_REG;
    end

    assign wr_reg   = perip_wen && (tgt == TGT_REG);
    assign tx_start = wr_reg && (reg_off == OFF_TXDATA) && perip_mask[0];

    always_ff @(posedge clk) begin
        if (perip_wen && (tgt == TGT_RAM)) begin
            for (int i = 0; i < 4; i++) begin
                if (perip_mask[i]) mem[ram_idx][8*i +: 8] <= perip_wdata[8*i +: 8];
            end
        end
    end

    // Overflow set takes priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud     <= BAUD_DIV_RST;
            overflow <= 1'b0;
            mtimecmp <= '1;
        end else begin
            if (wr_reg && (reg_off == OFF_BAUD)) begin
                for (int i = 0; i < 2; i++) begin
                    if (perip_mask[i]) baud[8*i +: 8] <= perip_wdata[8*i +: 8];
                end
            end
            if (tx_start && busy)
                overflow <= 1'b1;
            else if (wr_reg && (reg_off == OFF_STATUS) && perip_mask[0] && perip_wdata[1])
                overflow <= 1'b0;
            if (wr_reg && (reg_off == OFF_MTIMECMP_LO))
                mtimecmp[31:0] <= apply_mask(mtimecmp[31:0], perip_wdata, perip_mask);
            if (wr_reg && (reg_off == OFF_MTIMECMP_HI))
                mtimecmp[63:32] <= apply_mask(mtimecmp[63:32], perip_wdata, perip_mask);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime     <= 64'd0;
            timer_irq <= 1'b0;
        end else begin
            if (wr_reg && (reg_off == OFF_MTIME_LO))
                mtime[31:0] <= apply_mask(mtime[31:0], perip_wdata, perip_mask);
            else if (wr_reg && (reg_off == OFF_MTIME_HI))
                mtime[63:32] <= apply_mask(mtime[63:32], perip_wdata, perip_mask);
            else
                mtime <= mtime + 64'd1;
            timer_irq <= (mtime >= mtimecmp);
        end
    end

    uart_tx_fsm u_uart_tx_fsm (
        .clk   (clk),
        .rst   (rst),
        .baud  (baud),
        .start (tx_start),
        .data  (perip_wdata[7:0]),
        .tx    (uart_tx),
        .busy  (busy)
    );

    always_comb begin
        perip_rdata = 32'd0;
        case (tgt)
            TGT_RAM: perip_rdata = mem[ram_idx];
            TGT_REG: begin
                case (reg_off)
                    OFF_STATUS:      perip_rdata = {30'd0, overflow, busy};
                    OFF_BAUD:        perip_rdata = {16'd0, baud};
                    OFF_MTIME_LO:    perip_rdata = mtime[31:0];
                    OFF_MTIME_HI:    perip_rdata = mtime[63:32];
                    OFF_MTIMECMP_LO: perip_rdata = mtimecmp[31:0];
                    OFF_MTIMECMP_HI: perip_rdata = mtimecmp[63:32];
                    default:         perip_rdata = 32'd0;
                endcase
            end
            default: perip_rdata = 32'd0;
        endcase
    end

endmodule
